d_shift_register_universal: RTL and testbench

- Parametrised successor to the team's single-bit edge-triggered D flip-flop.
- A WIDTH-bit register with the same Q/Qn complementary outputs, plus eight operating modes: hold, shift, rotate, parallel load, clear and arithmetic shift.
- A burst engine repeats a mode for a programmed number of clocks and then signals completion.
- Used as the datapath register and serialiser/deserialiser primitive in the FlipFlops library.

---
 rtl/d_shift_register_universal.sv | 117 +++++++++++
 tb/tb_d_shift_register_universal.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/d_shift_register_universal.sv
// Universal WIDTH-bit shift register with hold/shift/rotate/load/clear/ASR modes
// and a burst engine that repeats a latched mode for CNT clocks, then pulses DONE.
module d_shift_register_universal #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             C,
  input  logic             Rn,
  input  logic [2:0]       M,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
  input  logic             START,
  input  logic [CW-1:0]    CNT,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             SOR,
  output logic             SOL,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] apply_mode(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d,
    input logic             sil,
    input logic             sir
  );
    logic [WIDTH-1:0] r;
    case (m)
      3'b000:  r = q;
      3'b001:  r = {sil, q[WIDTH-1:1]};
      3'b010:  r = {q[WIDTH-2:0], sir};
      3'b011:  r = d;
      3'b100:  r = {q[0], q[WIDTH-1:1]};
      3'b101:  r = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b110:  r = '0;
      default: r = {q[WIDTH-1], q[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          // A zero-length burst only acknowledges; the register is left alone.
          if (CNT == '0) begin
            done_d = 1'b1;
          end else begin
            mode_d = M;
            q_d    = apply_mode(M, q_q, D, SIL, SIR);
            if (CNT == CW'(1)) begin
              cnt_d  = '0;
              done_d = 1'b1;
            end else begin
              cnt_d   = CNT - CW'(1);
              state_d = BURST;
            end
          end
        end else begin
          q_d = apply_mode(M, q_q, D, SIL, SIR);
        end
      end
      default: begin
        q_d   = apply_mode(mode_q, q_q, D, SIL, SIR);
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
    busy_d = (state_d == BURST);
  end

  always_ff @(posedge C) begin
    if (!Rn) begin
      state_q <= IDLE;
      q_q     <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign Qn   = ~q_q;
  assign SOR  = q_q[0];
  assign SOL  = q_q[WIDTH-1];
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_d_shift_register_universal.sv
// Directed bench for d_shift_register_universal: modes, bursts, reset and corners.
module tb_d_shift_register_universal;

  logic       C = 1'b0;
  logic       Rn;
  logic [2:0] M;
  logic [7:0] D;
  logic       SIL, SIR, START;
  logic [3:0] CNT;
  logic [7:0] Q, Qn;
  logic       SOR, SOL, BUSY, DONE;

  int checks = 0;
  int fails  = 0;

  d_shift_register_universal #(.WIDTH(8), .CW(4)) dut (
    .C(C), .Rn(Rn), .M(M), .D(D), .SIL(SIL), .SIR(SIR), .START(START),
    .CNT(CNT), .Q(Q), .Qn(Qn), .SOR(SOR), .SOL(SOL), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 C = ~C;

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    M = 3'b011; D = v; START = 1'b0;
    step();
    M = 3'b000;
  endtask

  task automatic test_reset();
    Rn = 1'b0; M = 3'b011; D = 8'hFF; SIL = 0; SIR = 0; START = 0; CNT = 0;
    step();
    checks++; if (Q !== 8'h00) begin fails++; $display("FAIL reset_q got %h exp 00", Q); end
    checks++; if (Qn !== 8'hFF) begin fails++; $display("FAIL reset_qn got %h exp ff", Qn); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", DONE); end
    Rn = 1'b1; M = 3'b000;
  endtask

  task automatic test_rotate();
    load(8'hA5);
    checks++; if (Q !== 8'hA5) begin fails++; $display("FAIL load_q got %h exp a5", Q); end
    checks++; if (SOL !== 1'b1) begin fails++; $display("FAIL load_sol got %b exp 1", SOL); end
    M = 3'b100; step();
    checks++; if (Q !== 8'hD2) begin fails++; $display("FAIL rotr_q got %h exp d2", Q); end
    checks++; if (SOR !== 1'b0) begin fails++; $display("FAIL rotr_sor got %b exp 0", SOR); end
    M = 3'b101; step();
    checks++; if (Q !== 8'hA5) begin fails++; $display("FAIL rotl_q got %h exp a5", Q); end
    // Eight rotations preserve the pattern (and popcount)
    for (int i = 0; i < 8; i++) step();
    checks++; if (Q !== 8'hA5) begin fails++; $display("FAIL rotl8_q got %h exp a5", Q); end
    M = 3'b110; step();
    checks++; if (Q !== 8'h00) begin fails++; $display("FAIL clear_q got %h exp 00", Q); end
    M = 3'b000;
  endtask

  task automatic test_burst();
    load(8'h81);
    M = 3'b010; SIR = 1'b1; START = 1'b1; CNT = 4'd3;
    step();
    checks++; if (Q !== 8'h03) begin fails++; $display("FAIL burst_e1_q got %h exp 03", Q); end
    checks++; if (BUSY !== 1'b1) begin fails++; $display("FAIL burst_e1_busy got %b exp 1", BUSY); end
    checks++; if (DONE !== 1'b0) begin fails++; $display("FAIL burst_e1_done got %b exp 0", DONE); end
    START = 1'b0; M = 3'b001;
    step();
    checks++; if (Q !== 8'h07) begin fails++; $display("FAIL burst_e2_q got %h exp 07", Q); end
    checks++; if (BUSY !== 1'b1) begin fails++; $display("FAIL burst_e2_busy got %b exp 1", BUSY); end
    M = 3'b000;
    step();
    checks++; if (Q !== 8'h0F) begin fails++; $display("FAIL burst_e3_q got %h exp 0f", Q); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL burst_e3_busy got %b exp 0", BUSY); end
    checks++; if (DONE !== 1'b1) begin fails++; $display("FAIL burst_e3_done got %b exp 1", DONE); end
    step();
    checks++; if (DONE !== 1'b0) begin fails++; $display("FAIL burst_after_done got %b exp 0", DONE); end
    checks++; if (Q !== 8'h0F) begin fails++; $display("FAIL burst_after_q got %h exp 0f", Q); end
    SIR = 1'b0;
  endtask

  task automatic test_asr();
    load(8'h80);
    M = 3'b111;
    for (int i = 0; i < 4; i++) step();
    checks++; if (Q !== 8'hF8) begin fails++; $display("FAIL asr4_q got %h exp f8", Q); end
    M = 3'b001; SIL = 1'b0; step();
    checks++; if (Q !== 8'h7C) begin fails++; $display("FAIL shr_q got %h exp 7c", Q); end
    M = 3'b001; SIL = 1'b1; step();
    checks++; if (Q !== 8'hBE) begin fails++; $display("FAIL shr_sil_q got %h exp be", Q); end
    load(8'hFF);
    M = 3'b111; step();
    checks++; if (Q !== 8'hFF) begin fails++; $display("FAIL asr_ones_q got %h exp ff", Q); end
    M = 3'b010; SIR = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++; if (Q !== 8'h00) begin fails++; $display("FAIL shl8_q got %h exp 00", Q); end
    M = 3'b000; SIL = 1'b0;
  endtask

  task automatic test_burst_corner();
    int busy_cnt;
    load(8'h5A);
    M = 3'b100; START = 1'b1; CNT = 4'd0;
    step();
    checks++; if (Q !== 8'h5A) begin fails++; $display("FAIL cnt0_q got %h exp 5a", Q); end
    checks++; if (DONE !== 1'b1) begin fails++; $display("FAIL cnt0_done got %b exp 1", DONE); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL cnt0_busy got %b exp 0", BUSY); end
    START = 1'b0; M = 3'b000;
    step();
    checks++; if (DONE !== 1'b0) begin fails++; $display("FAIL cnt0_done2 got %b exp 0", DONE); end
    // CNT=1: single op, stays idle
    M = 3'b101; START = 1'b1; CNT = 4'd1;
    step();
    checks++; if (Q !== 8'hB4) begin fails++; $display("FAIL cnt1_q got %h exp b4", Q); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL cnt1_busy got %b exp 0", BUSY); end
    checks++; if (DONE !== 1'b1) begin fails++; $display("FAIL cnt1_done got %b exp 1", DONE); end
    START = 1'b0; M = 3'b000;
    load(8'h01);
    M = 3'b100; START = 1'b1; CNT = 4'd15;
    step();
    START = 1'b0; M = 3'b000;
    busy_cnt = (BUSY === 1'b1) ? 1 : 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (BUSY === 1'b1) busy_cnt++;
    end
    checks++; if (busy_cnt !== 14) begin fails++; $display("FAIL cnt15_busy_cycles got %0d exp 14", busy_cnt); end
    checks++; if (Q !== 8'h02) begin fails++; $display("FAIL cnt15_q got %h exp 02", Q); end
    checks++; if (DONE !== 1'b1) begin fails++; $display("FAIL cnt15_done got %b exp 1", DONE); end
    step();
    checks++; if (Q !== 8'h02) begin fails++; $display("FAIL cnt15_hold_q got %h exp 02", Q); end
  endtask

  task automatic test_reset_mid_burst();
    load(8'hFF);
    M = 3'b010; SIR = 1'b0; START = 1'b1; CNT = 4'd6;
    step();
    checks++; if (Q !== 8'hFE) begin fails++; $display("FAIL rb_e1_q got %h exp fe", Q); end
    START = 1'b0; M = 3'b000;
    step();
    checks++; if (Q !== 8'hFC) begin fails++; $display("FAIL rb_e2_q got %h exp fc", Q); end
    Rn = 1'b0;
    step();
    checks++; if (Q !== 8'h00) begin fails++; $display("FAIL rb_rst_q got %h exp 00", Q); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL rb_rst_busy got %b exp 0", BUSY); end
    Rn = 1'b1;
    step();
    checks++; if (DONE !== 1'b0) begin fails++; $display("FAIL rb_no_done got %b exp 0", DONE); end
    checks++; if (Q !== 8'h00) begin fails++; $display("FAIL rb_idle_q got %h exp 00", Q); end
    M = 3'b011; D = 8'h33; START = 1'b1; CNT = 4'd2;
    step();
    checks++; if (BUSY !== 1'b1) begin fails++; $display("FAIL rb_new_busy got %b exp 1", BUSY); end
    checks++; if (DONE !== 1'b0) begin fails++; $display("FAIL rb_new_done1 got %b exp 0", DONE); end
    START = 1'b0; M = 3'b000;
    step();
    checks++; if (DONE !== 1'b1) begin fails++; $display("FAIL rb_new_done2 got %b exp 1", DONE); end
    checks++; if (Q !== 8'h33) begin fails++; $display("FAIL rb_new_q got %h exp 33", Q); end
  endtask

  task automatic test_back_to_back();
    load(8'h01);
    M = 3'b100; START = 1'b1; CNT = 4'd2;
    step();
    checks++; if (Q !== 8'h80) begin fails++; $display("FAIL b2b_e1_q got %h exp 80", Q); end
    step();
    checks++; if (Q !== 8'h40 || DONE !== 1'b1) begin fails++; $display("FAIL b2b_e2 got q=%h done=%b exp q=40 done=1", Q, DONE); end
    step();
    checks++; if (Q !== 8'h20 || BUSY !== 1'b1 || DONE !== 1'b0) begin fails++; $display("FAIL b2b_e3 got q=%h busy=%b done=%b exp q=20 busy=1 done=0", Q, BUSY, DONE); end
    START = 1'b0; M = 3'b000;
    step();
    checks++; if (Q !== 8'h10 || DONE !== 1'b1) begin fails++; $display("FAIL b2b_e4 got q=%h done=%b exp q=10 done=1", Q, DONE); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_burst();
    test_asr();
    test_burst_corner();
    test_reset_mid_burst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
